// File: rtl/cordic_pkg.sv
// Shared constants, FSM states and arctangent table for the iterative CORDIC rotator.
// CORDIC_GAIN_COMP_EN adds the gain-compensation state.
package cordic_pkg;

    localparam int unsigned ATAN_W     = 32;
    localparam int unsigned STEP_W     = 5;
    localparam int unsigned KINV       = 39797;
    localparam int unsigned KINV_SHIFT = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
`ifdef CORDIC_GAIN_COMP_EN
        COMP = 2'd2,
`endif
        DONE = 2'd3
    } cordic_state_e;

    // atan(2^-idx) scaled so that 2^32 spans a full turn (pi/4 = 2^29)
    function automatic logic [ATAN_W-1:0] atan_full(input logic [STEP_W-1:0] idx);
        case (idx)
            5'd0:  return 32'd536870912;
            5'd1:  return 32'd316933406;
            5'd2:  return 32'd167458907;
            5'd3:  return 32'd85004756;
            5'd4:  return 32'd42667331;
            5'd5:  return 32'd21354465;
            5'd6:  return 32'd10679838;
            5'd7:  return 32'd5340245;
            5'd8:  return 32'd2670163;
            5'd9:  return 32'd1335087;
            5'd10: return 32'd667544;
            5'd11: return 32'd333772;
            5'd12: return 32'd166886;
            5'd13: return 32'd83443;
            5'd14: return 32'd41722;
            5'd15: return 32'd20861;
            5'd16: return 32'd10430;
            5'd17: return 32'd5215;
            5'd18: return 32'd2608;
            5'd19: return 32'd1304;
            5'd20: return 32'd652;
            5'd21: return 32'd326;
            5'd22: return 32'd163;
            5'd23: return 32'd81;
            5'd24: return 32'd41;
            5'd25: return 32'd20;
            5'd26: return 32'd10;
            5'd27: return 32'd5;
            5'd28: return 32'd3;
            5'd29: return 32'd1;
            5'd30: return 32'd1;
            default: return 32'd0;
        endcase
    endfunction

endpackage

// File: rtl/cordic_stage.sv
// One CORDIC micro-rotation: shift/add/sub of x, y and the angle accumulator.
module cordic_stage
    import cordic_pkg::*;
#(
    parameter int unsigned XW = 22,
    parameter int unsigned AW = 20
) (
    input  logic signed [XW-1:0]     x_i,
    input  logic signed [XW-1:0]     y_i,
    input  logic signed [AW-1:0]     z_i,
    input  logic        [STEP_W-1:0] shift_i,
    input  logic signed [AW-1:0]     atan_i,
    input  logic                     cw_i,
    output logic signed [XW-1:0]     x_o,
    output logic signed [XW-1:0]     y_o,
    output logic signed [AW-1:0]     z_o
);

    logic signed [XW-1:0] x_sh;
    logic signed [XW-1:0] y_sh;

    always_comb begin
        x_sh = x_i >>> shift_i;
        y_sh = y_i >>> shift_i;
        if (cw_i) begin
            x_o = x_i + y_sh;
            y_o = y_i - x_sh;
            z_o = z_i + atan_i;
        end else begin
            x_o = x_i - y_sh;
            y_o = y_i + x_sh;
            z_o = z_i - atan_i;
        end
    end

endmodule

// File: rtl/cordic_rotator_q.sv
// Iterative CORDIC rotator/vectorer with valid/ready handshakes, one micro-rotation per clock.
// Define CORDIC_GAIN_COMP_EN to scale x/y by 1/K in an extra COMP cycle.
module cordic_rotator_q
    import cordic_pkg::*;
#(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned GUARD_W = 4,
    parameter int unsigned ITERS   = 16
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_vector,
    input  logic signed [DATA_W-1:0] in_angle,
    input  logic signed [DATA_W-1:0] in_x,
    input  logic signed [DATA_W-1:0] in_y,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_angle,
    output logic signed [DATA_W-1:0] out_x,
    output logic signed [DATA_W-1:0] out_y
);

    localparam int unsigned XW = DATA_W + GUARD_W + 2;
    localparam int unsigned AW = DATA_W + GUARD_W;
    localparam int unsigned OW = DATA_W + 2;
    localparam logic signed [AW-1:0] QUARTER = {2'b01, {(AW-2){1'b0}}};

    cordic_state_e              state_q;
    logic        [STEP_W-1:0]   step_q;
    logic signed [XW-1:0]       x_q, y_q;
    logic signed [AW-1:0]       z_q;
    logic                       vec_q;
    logic                       out_valid_q;
    logic signed [DATA_W-1:0]   out_x_q, out_y_q, out_angle_q;

    logic                       accept;
    logic signed [XW-1:0]       x_ext, y_ext, pre_x, pre_y;
    logic signed [AW-1:0]       pre_z, atan_step, stg_z;
    logic signed [XW-1:0]       stg_x, stg_y;
    logic                       cw;
    logic                       last_step;

    // Clamp a guard-stripped accumulator to the signed output range
    function automatic logic signed [DATA_W-1:0] sat(input logic signed [OW-1:0] v);
        if ((v[OW-1:DATA_W-1] == 3'b000) || (v[OW-1:DATA_W-1] == 3'b111))
            return v[DATA_W-1:0];
        return v[OW-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    endfunction

    assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign last_step = (step_q == STEP_W'(ITERS - 1));
    assign cw        = vec_q ? ~y_q[XW-1] : z_q[AW-1];
    assign atan_step = AW'(atan_full(step_q) >> (ATAN_W - AW));

    // Quadrant pre-rotation so the iterations only need to cover +-pi/2
    always_comb begin
        x_ext = {{2{in_x[DATA_W-1]}}, in_x, {GUARD_W{1'b0}}};
        y_ext = {{2{in_y[DATA_W-1]}}, in_y, {GUARD_W{1'b0}}};
        pre_x = x_ext;
        pre_y = y_ext;
        pre_z = {in_angle, {GUARD_W{1'b0}}};
        if (in_vector) begin
            pre_z = '0;
            if (in_x[DATA_W-1]) begin
                if (!in_y[DATA_W-1]) begin
                    pre_x = y_ext;
                    pre_y = -x_ext;
                    pre_z = QUARTER;
                end else begin
                    pre_x = -y_ext;
                    pre_y = x_ext;
                    pre_z = -QUARTER;
                end
            end
        end else begin
            case (in_angle[DATA_W-1 -: 2])
                2'b01: begin
                    pre_x = -y_ext;
                    pre_y = x_ext;
                    pre_z = pre_z - QUARTER;
                end
                2'b10: begin
                    pre_x = y_ext;
                    pre_y = -x_ext;
                    pre_z = pre_z + QUARTER;
                end
                default: ;
            endcase
        end
    end

    cordic_stage #(
        .XW (XW),
        .AW (AW)
    ) u_stage (
        .x_i     (x_q),
        .y_i     (y_q),
        .z_i     (z_q),
        .shift_i (step_q),
        .atan_i  (atan_step),
        .cw_i    (cw),
        .x_o     (stg_x),
        .y_o     (stg_y),
        .z_o     (stg_z)
    );

`ifdef CORDIC_GAIN_COMP_EN
    logic signed [XW+17:0] kinv_s, prod_x, prod_y;
    assign kinv_s = (XW+18)'(KINV);
    assign prod_x = $signed({{18{x_q[XW-1]}}, x_q}) * kinv_s;
    assign prod_y = $signed({{18{y_q[XW-1]}}, y_q}) * kinv_s;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            step_q      <= '0;
            x_q         <= '0;
            y_q         <= '0;
            z_q         <= '0;
            vec_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_x_q     <= '0;
            out_y_q     <= '0;
            out_angle_q <= '0;
        end else begin
            if (accept) begin
                x_q     <= pre_x;
                y_q     <= pre_y;
                z_q     <= pre_z;
                vec_q   <= in_vector;
                step_q  <= '0;
                state_q <= ITER;
            end
            case (state_q)
                ITER: begin
                    x_q    <= stg_x;
                    y_q    <= stg_y;
                    z_q    <= stg_z;
                    step_q <= step_q + STEP_W'(1);
                    if (last_step) begin
`ifdef CORDIC_GAIN_COMP_EN
                        state_q     <= COMP;
`else
                        out_x_q     <= sat(OW'(stg_x >>> GUARD_W));
                        out_y_q     <= sat(OW'(stg_y >>> GUARD_W));
                        out_angle_q <= stg_z[AW-1:GUARD_W];
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
`endif
                    end
                end
`ifdef CORDIC_GAIN_COMP_EN
                COMP: begin
                    out_x_q     <= sat(OW'(prod_x >>> (KINV_SHIFT + GUARD_W)));
                    out_y_q     <= sat(OW'(prod_y >>> (KINV_SHIFT + GUARD_W)));
                    out_angle_q <= z_q[AW-1:GUARD_W];
                    out_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
`endif
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        if (!in_valid) state_q <= IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign out_x     = out_x_q;
    assign out_y     = out_y_q;
    assign out_angle = out_angle_q;

endmodule

// File: tb/tb_cordic_rotator_q.sv
// Self-checking bench for cordic_rotator_q against a real-arithmetic rotation/vectoring model.
module tb_cordic_rotator_q;

    localparam int DATA_W  = 16;
    localparam int GUARD_W = 4;
    localparam int ITERS   = 16;
`ifdef CORDIC_GAIN_COMP_EN
    localparam int  LAT   = ITERS + 1;
    localparam real KCOMP = 39797.0 / 65536.0;
`else
    localparam int  LAT   = ITERS;
    localparam real KCOMP = 1.0;
`endif
    localparam real PI = 3.14159265358979;

    logic                     clock;
    logic                     reset_n;
    logic                     in_valid;
    logic                     in_ready;
    logic                     in_vector;
    logic signed [DATA_W-1:0] in_angle, in_x, in_y;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [DATA_W-1:0] out_angle, out_x, out_y;

    int  total = 0;
    int  bad   = 0;
    real gain;
    real exp_x, exp_y, exp_a;
    real tol_a;

    cordic_rotator_q #(
        .DATA_W  (DATA_W),
        .GUARD_W (GUARD_W),
        .ITERS   (ITERS)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_vector (in_vector),
        .in_angle  (in_angle),
        .in_x      (in_x),
        .in_y      (in_y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_angle (out_angle),
        .out_x     (out_x),
        .out_y     (out_y)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic real clamp(input real v);
        if (v > 32767.0) return 32767.0;
        if (v < -32768.0) return -32768.0;
        return v;
    endfunction

    task automatic chk_eq(input string tag, input int obs, input int expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic chk_tol(input string tag, input int obs, input real expv, input real tol, input bit wrap);
        real d;
        bit  ok;
        d = real'(obs) - expv;
        if (wrap) begin
            while (d > 32768.0) d = d - 65536.0;
            while (d < -32768.0) d = d + 65536.0;
        end
        ok = (d <= tol) && (d >= -tol);
        total++;
        assert (ok === 1'b1) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0.2f tol=%0.1f", tag, obs, expv, tol);
        end
    endtask

    // Ideal rotation/vectoring scaled by the iteration gain
    task automatic issue(input bit vec, input int a, input int x, input int y, input real atol);
        real th;
        in_vector = vec;
        in_angle  = 16'(a);
        in_x      = 16'(x);
        in_y      = 16'(y);
        in_valid  = 1'b1;
        tol_a     = atol;
        if (!vec) begin
            th    = real'(a) * 2.0 * PI / 65536.0;
            exp_x = clamp(gain * (real'(x) * $cos(th) - real'(y) * $sin(th)));
            exp_y = clamp(gain * (real'(x) * $sin(th) + real'(y) * $cos(th)));
            exp_a = 0.0;
        end else begin
            exp_x = clamp(gain * $sqrt(real'(x) * real'(x) + real'(y) * real'(y)));
            exp_y = 0.0;
            exp_a = $atan2(real'(y), real'(x)) * 65536.0 / (2.0 * PI);
        end
    endtask

    task automatic accept_edge();
        @(posedge clock);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input string tag);
        int n;
        n = 0;
        while (!out_valid && n < LAT + 20) begin
            @(posedge clock);
            #1;
            n++;
        end
        chk_eq({tag, "_latency"}, n, LAT);
    endtask

    task automatic check_out(input string tag);
        chk_tol({tag, "_x"}, int'(out_x), exp_x, 4.0, 1'b0);
        chk_tol({tag, "_y"}, int'(out_y), exp_y, 4.0, 1'b0);
        chk_tol({tag, "_angle"}, int'(out_angle), exp_a, tol_a, 1'b1);
    endtask

    task automatic drain(input string tag);
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        out_ready = 1'b0;
        chk_eq({tag, "_valid_drop"}, int'(out_valid), 0);
    endtask

    task automatic run_op(input string tag, input bit vec, input int a, input int x, input int y, input real atol);
        chk_eq({tag, "_in_ready"}, int'(in_ready), 1);
        issue(vec, a, x, y, atol);
        accept_edge();
        wait_out(tag);
        check_out(tag);
        drain(tag);
    endtask

    initial begin
        logic [48:0] snap;
        bit          seen;
        int          rx, ry, ra;
        real         p;

        gain = 1.0;
        p    = 1.0;
        for (int i = 0; i < ITERS; i++) begin
            gain = gain * $sqrt(1.0 + p);
            p    = p / 4.0;
        end
        gain = gain * KCOMP;

        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_vector = 1'b0;
        in_angle  = '0;
        in_x      = '0;
        in_y      = '0;
        out_ready = 1'b0;
        #1;
        chk_eq("reset_out_valid", int'(out_valid), 0);
        chk_eq("reset_in_ready", int'(in_ready), 1);
        chk_eq("reset_out_x", int'(out_x), 0);
        chk_eq("reset_out_angle", int'(out_angle), 0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        run_op("rot_pi2", 1'b0, 16384, 10000, 0, 2.0);
        run_op("vec_pi", 1'b1, 0, -10000, 0, 2.0);
        run_op("vec_sat", 1'b1, 0, 32767, 32767, 4.0);
        run_op("rot_mpi", 1'b0, -32768, 8000, 3000, 2.0);
        run_op("rot_mpi2", 1'b0, -16384, 8000, 3000, 2.0);
        run_op("vec_q3", 1'b1, 0, -7000, -5000, 4.0);

        for (int k = 0; k < 8; k++) begin
            rx = int'($urandom_range(0, 24000)) - 12000;
            ry = int'($urandom_range(0, 24000)) - 12000;
            ra = int'($urandom_range(0, 65535)) - 32768;
            run_op("rand_rot", 1'b0, ra, rx, ry, 2.0);
        end
        for (int k = 0; k < 8; k++) begin
            do begin
                rx = int'($urandom_range(0, 24000)) - 12000;
                ry = int'($urandom_range(0, 24000)) - 12000;
            end while (rx * rx + ry * ry < 9000000);
            run_op("rand_vec", 1'b1, 0, rx, ry, 4.0);
        end

        // Backpressure then back-to-back transfer
        issue(1'b0, 4096, 9000, -2000, 2.0);
        accept_edge();
        wait_out("hold_a");
        check_out("hold_a");
        snap = {out_x, out_y, out_angle, out_valid};
        for (int c = 0; c < 5; c++) begin
            @(posedge clock);
            #1;
            chk_eq("hold_stable", int'({out_x, out_y, out_angle, out_valid} === snap), 1);
            chk_eq("hold_in_ready", int'(in_ready), 0);
        end
        issue(1'b1, 0, 5000, 7000, 4.0);
        out_ready = 1'b1;
        #1;
        chk_eq("b2b_in_ready", int'(in_ready), 1);
        accept_edge();
        out_ready = 1'b0;
        chk_eq("b2b_valid_drop", int'(out_valid), 0);
        chk_eq("b2b_busy", int'(in_ready), 0);
        wait_out("b2b");
        check_out("b2b");
        drain("b2b");

        // Reset in the middle of an operation
        issue(1'b0, 1000, 6000, 6000, 2.0);
        accept_edge();
        repeat (7) @(posedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        chk_eq("midrst_out_valid", int'(out_valid), 0);
        chk_eq("midrst_in_ready", int'(in_ready), 1);
        @(negedge clock);
        reset_n = 1'b1;
        seen = 1'b0;
        repeat (LAT + 4) begin
            @(posedge clock);
            #1;
            if (out_valid) seen = 1'b1;
        end
        chk_eq("midrst_no_valid", int'(seen), 0);
        run_op("post_rst", 1'b0, -12000, 7000, 1000, 2.0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
